// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, CTRL/STATUS
// bit positions and reset constants.
package timer_pkg;

    // Byte offsets; the slave decodes only offset[4:2].
    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_PRESCALE = 5'h04;
    localparam logic [4:0] OFF_COMPARE  = 5'h08;
    localparam logic [4:0] OFF_COUNT    = 5'h0C;
    localparam logic [4:0] OFF_STATUS   = 5'h10;
    localparam logic [4:0] OFF_CAPTURE  = 5'h14;

    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_W           = 3;

    localparam int STATUS_MATCH   = 0;
    localparam int STATUS_CAPTURE = 1;

    localparam int PRESCALE_W = 16;

    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

    function automatic logic [2:0] reg_index(input logic [4:0] offset);
        return offset[4:2];
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: counts enabled cycles and emits one tick each time
// the count reaches limit, then wraps to zero.
module timer_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] limit,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == limit);
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mm_timer_slave.sv
// Memory-mapped compare/auto-reload timer with prescaler and interrupt.
// Optional input-capture unit built only when TIMER_CAPTURE_EN is defined.
module mm_timer_slave
    import timer_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] COUNT_RESET = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [31:0]           address,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  irq
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic                  capture_in
`endif
);

    logic [CTRL_W-1:0]     ctrl_q,     ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [DATA_WIDTH-1:0] compare_q,  compare_d;
    logic [DATA_WIDTH-1:0] count_q,    count_d;
    logic                  match_q,    match_d;

    logic [2:0] sel;
    logic       wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
    logic       tick, hit, presc_clr;
    logic       cap_flag;
    logic [DATA_WIDTH-1:0] capture_rd;
    logic [DATA_WIDTH-1:0] rd_mux;

    logic unused_addr;
    assign unused_addr = &{1'b0, address[31:5], address[1:0]};

    assign sel         = address[4:2];
    assign wr_ctrl     = we && (sel == reg_index(OFF_CTRL));
    assign wr_prescale = we && (sel == reg_index(OFF_PRESCALE));
    assign wr_compare  = we && (sel == reg_index(OFF_COMPARE));
    assign wr_count    = we && (sel == reg_index(OFF_COUNT));
    assign wr_status   = we && (sel == reg_index(OFF_STATUS));

    // A rising enable restarts the prescale period so the first tick is a full period away.
    assign presc_clr = wr_ctrl && wd[CTRL_ENABLE] && !ctrl_q[CTRL_ENABLE];

    timer_prescaler u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl_q[CTRL_ENABLE]),
        .clr   (presc_clr),
        .limit (prescale_q),
        .tick  (tick)
    );

    assign hit = tick && (count_q == compare_q);

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;

        if (tick) begin
            if (!hit) begin
                count_d = count_q + DATA_WIDTH'(1);
            end else if (ctrl_q[CTRL_AUTO_RELOAD]) begin
                count_d = '0;
            end else begin
                ctrl_d[CTRL_ENABLE] = 1'b0;
            end
        end

        // Bus writes are applied last so they override same-cycle timer updates.
        if (wr_ctrl)     ctrl_d     = wd[CTRL_W-1:0];
        if (wr_prescale) prescale_d = wd[PRESCALE_W-1:0];
        if (wr_compare)  compare_d  = wd;
        if (wr_count)    count_d    = wd;

        match_d = (match_q && !(wr_status && wd[STATUS_MATCH])) || hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            compare_q  <= DATA_WIDTH'(COMPARE_RESET);
            count_q    <= COUNT_RESET;
            match_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            match_q    <= match_d;
        end
    end

`ifdef TIMER_CAPTURE_EN
    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] remembers the previous level.
    logic [2:0]            sync_q,     sync_d;
    logic [DATA_WIDTH-1:0] capture_q,  capture_d;
    logic                  cap_flag_q, cap_flag_d;
    logic                  cap_rise;

    always_comb begin
        sync_d     = {sync_q[1:0], capture_in};
        cap_rise   = sync_q[1] && !sync_q[2];
        capture_d  = cap_rise ? count_q : capture_q;
        cap_flag_d = (cap_flag_q && !(wr_status && wd[STATUS_CAPTURE])) || cap_rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            capture_q  <= '0;
            cap_flag_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            capture_q  <= capture_d;
            cap_flag_q <= cap_flag_d;
        end
    end

    assign cap_flag   = cap_flag_q;
    assign capture_rd = capture_q;
`else
    assign cap_flag   = 1'b0;
    assign capture_rd = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (sel)
            reg_index(OFF_CTRL):     rd_mux = DATA_WIDTH'(ctrl_q);
            reg_index(OFF_PRESCALE): rd_mux = DATA_WIDTH'(prescale_q);
            reg_index(OFF_COMPARE):  rd_mux = compare_q;
            reg_index(OFF_COUNT):    rd_mux = count_q;
            reg_index(OFF_STATUS):   rd_mux = DATA_WIDTH'({cap_flag, match_q});
            reg_index(OFF_CAPTURE):  rd_mux = capture_rd;
            default:                 rd_mux = '0;
        endcase
        rd = re ? rd_mux : '0;
    end

    assign irq = match_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_mm_timer_slave.sv
// Directed self-checking bench for mm_timer_slave (capture test built when TIMER_CAPTURE_EN is defined).
module tb_mm_timer_slave;

    localparam logic [31:0] A_CTRL     = 32'h00;
    localparam logic [31:0] A_PRESCALE = 32'h04;
    localparam logic [31:0] A_COMPARE  = 32'h08;
    localparam logic [31:0] A_COUNT    = 32'h0C;
    localparam logic [31:0] A_STATUS   = 32'h10;
    localparam logic [31:0] A_CAPTURE  = 32'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wd;
    logic [31:0] address;
    logic        we;
    logic        re;
    logic [31:0] rd;
    logic        irq;
`ifdef TIMER_CAPTURE_EN
    logic        capture_in;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mm_timer_slave #(.DATA_WIDTH(32), .COUNT_RESET(32'h0)) dut (
        .clk     (clk),
        .rst     (rst),
        .wd      (wd),
        .address (address),
        .we      (we),
        .re      (re),
        .rd      (rd),
        .irq     (irq)
`ifdef TIMER_CAPTURE_EN
        ,
        .capture_in (capture_in)
`endif
    );

    always #5 clk = ~clk;

    // Called at a negedge; one rising edge performs the write, returns at the next negedge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        address = a;
        wd      = d;
        we      = 1'b1;
        @(negedge clk);
        we      = 1'b0;
    endtask

    // Combinational read inside the low phase; consumes no clock edge.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        address = a;
        re      = 1'b1;
        #1;
        d  = rd;
        re = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        bus_read(A_CTRL, r);     n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h want %h", r, 32'h0); end
        bus_read(A_PRESCALE, r); n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL reset_prescale: got %h want %h", r, 32'h0); end
        bus_read(A_COMPARE, r);  n_cmp++; if (r !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL reset_compare: got %h want %h", r, 32'hFFFFFFFF); end
        bus_read(A_COUNT, r);    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL reset_count: got %h want %h", r, 32'h0); end
        bus_read(A_STATUS, r);   n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h want %h", r, 32'h0); end
        bus_read(A_CAPTURE, r);  n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL reset_capture: got %h want %h", r, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want %b", irq, 1'b0); end
        address = A_COMPARE; re = 1'b0; #1;
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_rd_re_low: got %h want %h", rd, 32'h0); end
    endtask

    task automatic test_bus();
        logic [31:0] r;
        bus_read(32'h18, r); n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL unmapped_18: got %h want %h", r, 32'h0); end
        bus_read(32'h1C, r); n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL unmapped_1c: got %h want %h", r, 32'h0); end
        bus_write(32'h18, 32'hFFFFFFFF);
        bus_read(A_CTRL, r);    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL unmapped_write_ctrl: got %h want %h", r, 32'h0); end
        bus_read(A_COMPARE, r); n_cmp++; if (r !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL unmapped_write_compare: got %h want %h", r, 32'hFFFFFFFF); end
        bus_write(A_CTRL, 32'hFFFFFFF8);
        bus_read(A_CTRL, r); n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL ctrl_upper_bits: got %h want %h", r, 32'h0); end
        bus_write(A_PRESCALE, 32'hABCD1234);
        bus_read(A_PRESCALE, r); n_cmp++; if (r !== 32'h00001234) begin n_bad++; $display("FAIL prescale_16bit: got %h want %h", r, 32'h00001234); end
        bus_write(A_PRESCALE, 32'h0);
        // Read and write of the same register in one cycle returns the old value.
        address = A_COMPARE; wd = 32'h77; we = 1'b1; re = 1'b1; #1;
        n_cmp++; if (rd !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL rw_same_cycle: got %h want %h", rd, 32'hFFFFFFFF); end
        @(negedge clk); we = 1'b0; re = 1'b0;
        bus_read(A_COMPARE, r); n_cmp++; if (r !== 32'h77) begin n_bad++; $display("FAIL rw_after_write: got %h want %h", r, 32'h77); end
        bus_write(A_COUNT, 32'h1234);
        bus_read(32'h0F, r); n_cmp++; if (r !== 32'h1234) begin n_bad++; $display("FAIL byte_lanes_ignored: got %h want %h", r, 32'h1234); end
    endtask

    task automatic test_tick_rate();
        logic [31:0] r;
        bus_write(A_PRESCALE, 32'd3);
        bus_write(A_COMPARE, 32'd100);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CTRL, 32'h1);
        cycles(3);
        bus_read(A_COUNT, r); n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL rate_before_tick: got %h want %h", r, 32'd0); end
        cycles(1);
        bus_read(A_COUNT, r); n_cmp++; if (r !== 32'd1) begin n_bad++; $display("FAIL rate_first_tick: got %h want %h", r, 32'd1); end
        cycles(4);
        bus_read(A_COUNT, r); n_cmp++; if (r !== 32'd2) begin n_bad++; $display("FAIL rate_second_tick: got %h want %h", r, 32'd2); end
        cycles(392);
        bus_read(A_COUNT, r); n_cmp++; if (r !== 32'd100) begin n_bad++; $display("FAIL rate_reach_100: got %h want %h", r, 32'd100); end
        cycles(3);
        bus_read(A_STATUS, r); n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL rate_no_early_match: got %h want %h", r, 32'h0); end
        cycles(1);
        bus_read(A_STATUS, r); n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL rate_match: got %h want %h", r, 32'h1); end
        bus_read(A_CTRL, r);   n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL rate_autostop_ctrl: got %h want %h", r, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rate_irq_masked: got %b want %b", irq, 1'b0); end
        cycles(8);
        bus_read(A_COUNT, r); n_cmp++; if (r !== 32'd100) begin n_bad++; $display("FAIL rate_hold: got %h want %h", r, 32'd100); end
        bus_write(A_STATUS, 32'h1);
        bus_read(A_STATUS, r); n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL rate_w1c: got %h want %h", r, 32'h0); end
    endtask

    task automatic test_auto_reload_irq();
        logic [31:0] r;
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_COMPARE, 32'd5);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CTRL, 32'h7);
        cycles(5);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL ar_irq_early: got %b want %b", irq, 1'b0); end
        bus_read(A_COUNT, r); n_cmp++; if (r !== 32'd5) begin n_bad++; $display("FAIL ar_count_5: got %h want %h", r, 32'd5); end
        cycles(1);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL ar_irq_set: got %b want %b", irq, 1'b1); end
        bus_read(A_COUNT, r); n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL ar_reload: got %h want %h", r, 32'd0); end
        bus_write(A_STATUS, 32'h1);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL ar_irq_clear: got %b want %b", irq, 1'b0); end
        bus_read(A_COUNT, r); n_cmp++; if (r !== 32'd1) begin n_bad++; $display("FAIL ar_continue: got %h want %h", r, 32'd1); end
        bus_write(A_CTRL, 32'h0);
    endtask

    task automatic test_wrap();
        logic [31:0] r;
        logic [31:0] exp_cnt [5];
        exp_cnt[0] = 32'hFFFFFFFF; exp_cnt[1] = 32'h0; exp_cnt[2] = 32'h1; exp_cnt[3] = 32'h2; exp_cnt[4] = 32'h3;
        bus_write(A_STATUS, 32'h3);
        bus_write(A_COUNT, 32'hFFFFFFFE);
        bus_write(A_COMPARE, 32'd3);
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_CTRL, 32'h1);
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            bus_read(A_COUNT, r);  n_cmp++; if (r !== exp_cnt[i]) begin n_bad++; $display("FAIL wrap_count[%0d]: got %h want %h", i, r, exp_cnt[i]); end
            bus_read(A_STATUS, r); n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL wrap_status[%0d]: got %h want %h", i, r, 32'h0); end
        end
        cycles(1);
        bus_read(A_STATUS, r); n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL wrap_match: got %h want %h", r, 32'h1); end
        bus_read(A_COUNT, r);  n_cmp++; if (r !== 32'h3) begin n_bad++; $display("FAIL wrap_hold: got %h want %h", r, 32'h3); end
        bus_write(A_STATUS, 32'h1);
    endtask

    task automatic test_collisions();
        logic [31:0] r;
        bus_write(A_COMPARE, 32'd1000);
        bus_write(A_COUNT, 32'h10);
        bus_write(A_CTRL, 32'h1);
        cycles(2);
        bus_read(A_COUNT, r); n_cmp++; if (r !== 32'h12) begin n_bad++; $display("FAIL col_pre: got %h want %h", r, 32'h12); end
        bus_write(A_COUNT, 32'h50);
        bus_read(A_COUNT, r); n_cmp++; if (r !== 32'h50) begin n_bad++; $display("FAIL col_count_write_wins: got %h want %h", r, 32'h50); end
        cycles(1);
        bus_read(A_COUNT, r); n_cmp++; if (r !== 32'h51) begin n_bad++; $display("FAIL col_after_write: got %h want %h", r, 32'h51); end
        bus_write(A_COMPARE, 32'h55);
        cycles(3);
        bus_read(A_COUNT, r);  n_cmp++; if (r !== 32'h55) begin n_bad++; $display("FAIL col_at_compare: got %h want %h", r, 32'h55); end
        bus_read(A_STATUS, r); n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL col_status_pre: got %h want %h", r, 32'h0); end
        bus_write(A_STATUS, 32'h1);
        bus_read(A_STATUS, r); n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL col_set_beats_w1c: got %h want %h", r, 32'h1); end
        bus_read(A_CTRL, r);   n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL col_autostop: got %h want %h", r, 32'h0); end
        bus_write(A_STATUS, 32'h1);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_CTRL, 32'h3);
        bus_read(A_CTRL, r);   n_cmp++; if (r !== 32'h3) begin n_bad++; $display("FAIL col_ctrl_write_wins: got %h want %h", r, 32'h3); end
        bus_read(A_COUNT, r);  n_cmp++; if (r !== 32'h55) begin n_bad++; $display("FAIL col_stop_hold: got %h want %h", r, 32'h55); end
        bus_read(A_STATUS, r); n_cmp++; if (r !== 32'h1) begin n_bad++; $display("FAIL col_stop_match: got %h want %h", r, 32'h1); end
        bus_write(A_CTRL, 32'h0);
        bus_read(A_COUNT, r);  n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL col_reload: got %h want %h", r, 32'h0); end
        bus_write(A_STATUS, 32'h1);
    endtask

`ifdef TIMER_CAPTURE_EN
    task automatic test_capture();
        logic [31:0] r;
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_COMPARE, 32'h1000);
        bus_write(A_COUNT, 32'h1F);
        bus_write(A_CTRL, 32'h1);
        cycles(1);
        capture_in = 1'b1;
        cycles(1);
        capture_in = 1'b0;
        cycles(2);
        bus_write(A_CTRL, 32'h0);
        bus_read(A_CAPTURE, r); n_cmp++; if (r !== 32'h22) begin n_bad++; $display("FAIL capture_value: got %h want %h", r, 32'h22); end
        bus_read(A_STATUS, r);  n_cmp++; if (r !== 32'h2) begin n_bad++; $display("FAIL capture_flag: got %h want %h", r, 32'h2); end
        bus_write(A_CAPTURE, 32'h0);
        bus_read(A_CAPTURE, r); n_cmp++; if (r !== 32'h22) begin n_bad++; $display("FAIL capture_readonly: got %h want %h", r, 32'h22); end
        bus_write(A_STATUS, 32'h2);
        bus_read(A_STATUS, r);  n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL capture_w1c: got %h want %h", r, 32'h0); end
    endtask
`endif

    task automatic test_reset_mid_count();
        logic [31:0] r;
        bus_write(A_PRESCALE, 32'd1);
        bus_write(A_COMPARE, 32'h42);
        bus_write(A_COUNT, 32'h40);
        bus_write(A_CTRL, 32'h7);
        cycles(6);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL mid_irq_before: got %b want %b", irq, 1'b1); end
        cycles(1);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mid_irq_async: got %b want %b", irq, 1'b0); end
        bus_read(A_COMPARE, r); n_cmp++; if (r !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mid_compare_async: got %h want %h", r, 32'hFFFFFFFF); end
        @(negedge clk);
        rst = 1'b0;
        bus_read(A_CTRL, r);     n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL mid_ctrl: got %h want %h", r, 32'h0); end
        bus_read(A_PRESCALE, r); n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL mid_prescale: got %h want %h", r, 32'h0); end
        bus_read(A_COMPARE, r);  n_cmp++; if (r !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mid_compare: got %h want %h", r, 32'hFFFFFFFF); end
        cycles(6);
        bus_read(A_COUNT, r);    n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL mid_count: got %h want %h", r, 32'h0); end
        bus_read(A_STATUS, r);   n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL mid_status: got %h want %h", r, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mid_irq_after: got %b want %b", irq, 1'b0); end
    endtask

    initial begin
        rst     = 1'b1;
        we      = 1'b0;
        re      = 1'b0;
        wd      = '0;
        address = '0;
`ifdef TIMER_CAPTURE_EN
        capture_in = 1'b0;
`endif
        cycles(2);
        rst = 1'b0;
        test_reset();
        test_bus();
        test_tick_rate();
        test_auto_reload_irq();
        test_wrap();
        test_collisions();
`ifdef TIMER_CAPTURE_EN
        test_capture();
`endif
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
